// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver slice.
// Holds the receiver state encoding and the default frame geometry
// (clocks per serial bit, data bits per frame) used by uart_rx_entry.
package uart_rx_pkg;

  localparam int DefaultClksPerBit = 5;
  localparam int DefaultDataBits   = 8;

  // PARITY is only entered when the receiver is built with UART_RX_PARITY_EN.
  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input.
// Both flops reset to 1 so the line reads idle while rst_n is low.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   d_i    raw asynchronous serial line
//   q_o    synchronised line, two clocks behind d_i
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First stage may go metastable; the second stage gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_entry.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit.
// The line is oversampled with clk and each bit is sampled at its midpoint.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the last data bit and the stop bit, plus the parity_err output.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   rx_data    last correctly framed byte, bit0 = first received
//   rx_valid   one-cycle pulse when rx_data is updated
//   frame_err  one-cycle pulse when the stop bit was sampled low
//   parity_err one-cycle pulse on parity mismatch (UART_RX_PARITY_EN only)
//   busy       high while a frame is in progress (START..STOP)
module uart_rx_entry
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DefaultClksPerBit,
  parameter int DATA_BITS    = DefaultDataBits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TickW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickLast  = TickW'(CLKS_PER_BIT - 1);
  // The edge-detect cycle in IDLE already counts as tick 0 of the start bit,
  // so START reaches the midpoint one count earlier than CLKS_PER_BIT/2.
  localparam logic [TickW-1:0] TickHalf  = TickW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0]  BitLast   = BitW'(DATA_BITS - 1);

  rxState_e             state_q;
  logic [TickW-1:0]     tickCnt_q;
  logic [BitW-1:0]      bitCnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 rxPrev_q;
  logic [DATA_BITS-1:0] rxData_q;
  logic                 rxValid_q;
  logic                 frameErr_q;
  logic                 busy_q;
  logic                 rxS;
`ifdef UART_RX_PARITY_EN
  logic                 parityBad_q;
  logic                 parityErr_q;
`endif

  uart_rx_sync uSync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rxS)
  );

  // New bits enter at the MSB so the first received bit ends up in bit 0.
  assign shift_d = {rxS, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARM;
      tickCnt_q   <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      rxPrev_q    <= 1'b1;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr_q <= 1'b0;
`endif
      rxPrev_q   <= rxS;
      case (state_q)
        // A line held low (out of reset or after a break) must go high first.
        ARM: begin
          if (rxS) state_q <= IDLE;
        end
        IDLE: begin
          if (rxPrev_q && !rxS) begin
            state_q   <= START;
            tickCnt_q <= '0;
            bitCnt_q  <= '0;
            busy_q    <= 1'b1;
          end
        end
        // A start bit that is high again at its midpoint was a glitch.
        START: begin
          if (tickCnt_q == TickHalf) begin
            tickCnt_q <= '0;
            if (!rxS) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            tickCnt_q <= tickCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tickCnt_q == TickLast) begin
            tickCnt_q <= '0;
            shift_q   <= shift_d;
            if (bitCnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end else begin
            tickCnt_q <= tickCnt_q + 1'b1;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tickCnt_q == TickLast) begin
            tickCnt_q   <= '0;
            parityBad_q <= (^shift_q) ^ rxS;
            state_q     <= STOP;
          end else begin
            tickCnt_q <= tickCnt_q + 1'b1;
          end
`else
          state_q <= ARM;
          busy_q  <= 1'b0;
`endif
        end
        // A low stop bit takes priority over any parity result.
        STOP: begin
          if (tickCnt_q == TickLast) begin
            tickCnt_q <= '0;
            busy_q    <= 1'b0;
            if (rxS) begin
              state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (parityBad_q) begin
                parityErr_q <= 1'b1;
              end else begin
                rxData_q  <= shift_q;
                rxValid_q <= 1'b1;
              end
`else
              rxData_q  <= shift_q;
              rxValid_q <= 1'b1;
`endif
            end else begin
              state_q    <= ARM;
              frameErr_q <= 1'b1;
            end
          end else begin
            tickCnt_q <= tickCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ARM;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`endif

endmodule

// File: tb/tb_uart_rx_entry.sv
// Scoreboard bench for uart_rx_entry: each driven frame pushes its expected
// strobe kind and rx_data value; the monitor pops and compares on each strobe.
module tb_uart_rx_entry;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`else
  logic       parity_err;
  assign parity_err = 1'b0;
`endif

  // Kind bits: {parity_err, frame_err, rx_valid}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } expEntry_t;

  expEntry_t expQ[$];
  int        checks;
  int        errors;
  int        strobeCount;
  int        pushCount;
  logic [7:0] lastGood;

  uart_rx_entry dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  // Posedges land at 15 mod 20 ns, so line changes at 10 mod 20 ns stay clear of them.
  initial begin
    clk = 1'b0;
    #5;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic pushExpect(input logic [2:0] kind, input logic [7:0] data);
    expEntry_t e;
    e.kind = kind;
    e.data = data;
    expQ.push_back(e);
    pushCount++;
  endtask

  // Drives one frame at 100 ns per bit; the line is left at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badParity);
    if (!stopBit) begin
      pushExpect(3'b010, lastGood);
    end else if (badParity) begin
      pushExpect(3'b100, lastGood);
    end else begin
      pushExpect(3'b001, data);
      lastGood = data;
    end
    rx = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #100;
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ badParity;
    #100;
`endif
    rx = stopBit;
    #100;
  endtask

  // Monitor samples on the falling edge, away from the updating edge.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err || parity_err)) begin
      strobeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", {29'd0, parity_err, frame_err, rx_valid}, 32'd0);
      end else begin
        expEntry_t e;
        e = expQ.pop_front();
        checkOutput("strobe_kind", {29'd0, parity_err, frame_err, rx_valid}, {29'd0, e.kind});
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    strobeCount = 0;
    pushCount   = 0;
    lastGood    = 8'h00;
    rst_n       = 1'b0;
    rx          = 1'b0;

    #20;
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    #20 rst_n = 1'b1;

    // Line held low out of reset must not start a frame.
    #50 rx = 1'b1;
    #60;
    checkOutput("armed_no_strobe", strobeCount, 0);
    checkOutput("armed_busy", {31'd0, busy}, 32'd0);

    #40;
    applyStimulus(8'hD5, 1'b1, 1'b0);
    #200;

    // Single-clock glitch must be rejected at the start-bit midpoint.
    rx = 1'b0;
    #20 rx = 1'b1;
    #200;
    applyStimulus(8'h3C, 1'b1, 1'b0);
    #200;

    // Stop bit low: framing error, rx_data holds 0x3C, no reception while low.
    applyStimulus(8'hD5, 1'b0, 1'b0);
    #300;
    checkOutput("break_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    #200;

    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    #200;

    // Abort a frame partway through the data bits.
    rx = 1'b0;
    #100 rx = 1'b1;
    #100 rx = 1'b0;
    #100;
    checkOutput("busy_mid_frame", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #10;
    checkOutput("abort_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    lastGood = 8'h00;
    rx = 1'b1;
    #20 rst_n = 1'b1;
    #190;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    #400;

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'hD5, 1'b1, 1'b1);
    #400;
`endif

    checkOutput("pending_expects", expQ.size(), 0);
    checkOutput("strobe_count", strobeCount, pushCount);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
